// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the round-robin priority encoder.
//   prio_mode_e  : arbitration mode carried on the mode input
//   prio_state_e : handshake state (EMPTY / HOLD), mirrored on out_valid
//   clog2_min1   : index width that never collapses to zero bits
package prio_enc_pkg;

  typedef enum logic {PRIO_FIXED = 1'b0, PRIO_RR = 1'b1} prio_mode_e;

  typedef enum logic {ST_EMPTY = 1'b0, ST_HOLD = 1'b1} prio_state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Combinational lowest-set-bit encoder.
//   i_in    in  N  input vector
//   o_found out 1  any bit of i_in set
//   o_idx   out W  index of the lowest set bit (0 when none set)
module prio_enc_lsb
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic [N-1:0] i_in,
  output logic         o_found,
  output logic [W-1:0] o_idx
);

  assign o_found = |i_in;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_in[i]) o_idx = W'(i);
    end
  end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder, fixed or round-robin, with a
// valid/ready output handshake. A grant is held stable until accepted.
//   clk        in   1  rising-edge clock
//   rst        in   1  synchronous active-high reset
//   req        in   N  request vector
//   mode       in   1  0 = fixed (LSB wins), 1 = round-robin
//   out_valid  out  1  grant valid
//   out_ready  in   1  consumer accepts when out_valid && out_ready
//   out_code   out  W  granted index
//   out_onehot out  N  one-hot grant, zero when !out_valid
//   ptr        out  W  round-robin base index
//
// state    | meaning
// ST_EMPTY | no grant held, outputs zero, waiting for any request
// ST_HOLD  | grant held on out_code/out_onehot until accepted
module prio_encoder_rr
  import prio_enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2_min1(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_code,
  output logic [N-1:0] out_onehot,
  output logic [W-1:0] ptr
);

  prio_state_e r_state;
  logic [W-1:0] r_code;
  logic [N-1:0] r_onehot;
  logic [W-1:0] r_ptr;

  prio_mode_e   w_mode;
  logic         w_accept;
  logic [W-1:0] w_ptr_adv;
  logic [W-1:0] w_ptr_eff;
  logic [N-1:0] w_mask;
  logic         w_m_found;
  logic [W-1:0] w_m_idx;
  logic         w_r_found;
  logic [W-1:0] w_r_idx;
  logic [W-1:0] w_code_win;

  assign w_mode   = prio_mode_e'(mode);
  assign w_accept = (r_state == ST_HOLD) && out_ready;

  // Wrap at N-1 rather than 2^W-1 so ptr never leaves the request range.
  assign w_ptr_adv = (r_code == W'(N - 1)) ? '0 : W'({1'b0, r_code} + (W + 1)'(1));

  // A same-cycle accept/recapture must see the pointer it is about to load.
  assign w_ptr_eff = (w_accept && w_mode == PRIO_RR) ? w_ptr_adv : r_ptr;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = ((W + 1)'(i) >= {1'b0, w_ptr_eff});
    end
  end

  prio_enc_lsb #(.N(N)) u_lsb_masked (
    .i_in    (req & w_mask),
    .o_found (w_m_found),
    .o_idx   (w_m_idx)
  );

  prio_enc_lsb #(.N(N)) u_lsb_raw (
    .i_in    (req),
    .o_found (w_r_found),
    .o_idx   (w_r_idx)
  );

  // Nothing at or above ptr falls back to the raw search, which is the wrap.
  assign w_code_win = (w_mode == PRIO_RR && w_m_found) ? w_m_idx : w_r_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_EMPTY;
      r_code   <= '0;
      r_onehot <= '0;
      r_ptr    <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_r_found) begin
            r_state  <= ST_HOLD;
            r_code   <= w_code_win;
            r_onehot <= {{(N - 1){1'b0}}, 1'b1} << w_code_win;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (w_mode == PRIO_RR) r_ptr <= w_ptr_adv;
            if (w_r_found) begin
              r_code   <= w_code_win;
              r_onehot <= {{(N - 1){1'b0}}, 1'b1} << w_code_win;
            end else begin
              r_state  <= ST_EMPTY;
              r_code   <= '0;
              r_onehot <= '0;
            end
          end
        end
        default: begin
          r_state  <= ST_EMPTY;
          r_code   <= '0;
          r_onehot <= '0;
        end
      endcase
    end
  end

  assign out_valid  = (r_state == ST_HOLD);
  assign out_code   = r_code;
  assign out_onehot = r_onehot;
  assign ptr        = r_ptr;

endmodule

// File: tb/tb_prio_encoder_rr.sv
module tb_prio_encoder_rr;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic       mode;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_code;
  logic [7:0] out_onehot;
  logic [2:0] ptr;

  logic       rst5;
  logic [4:0] req5;
  logic       mode5;
  logic       valid5;
  logic       ready5;
  logic [2:0] code5;
  logic [4:0] onehot5;
  logic [2:0] ptr5;

  int n_tests = 0;
  int n_fail  = 0;

  prio_encoder_rr #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_code   (out_code),
    .out_onehot (out_onehot),
    .ptr        (ptr)
  );

  prio_encoder_rr #(.N(5)) dut5 (
    .clk        (clk),
    .rst        (rst5),
    .req        (req5),
    .mode       (mode5),
    .out_valid  (valid5),
    .out_ready  (ready5),
    .out_code   (code5),
    .out_onehot (onehot5),
    .ptr        (ptr5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk8(input string tag, input logic v, input logic [2:0] c,
                      input logic [7:0] oh, input logic [2:0] p);
    chk({tag, ".valid"},  32'(out_valid),  32'(v));
    chk({tag, ".code"},   32'(out_code),   32'(c));
    chk({tag, ".onehot"}, 32'(out_onehot), 32'(oh));
    chk({tag, ".ptr"},    32'(ptr),        32'(p));
  endtask

  // round-robin expectations for req=1001_0100 starting from ptr 0
  logic [2:0] rr_code [5] = '{3'd2, 3'd4, 3'd7, 3'd2, 3'd4};
  logic [7:0] rr_oh   [5] = '{8'h04, 8'h10, 8'h80, 8'h04, 8'h10};
  logic [2:0] rr_ptr  [5] = '{3'd0, 3'd3, 3'd5, 3'd0, 3'd3};

  logic [2:0] w5_code [4] = '{3'd0, 3'd4, 3'd0, 3'd4};
  logic [4:0] w5_oh   [4] = '{5'h01, 5'h10, 5'h01, 5'h10};
  logic [2:0] w5_ptr  [4] = '{3'd0, 3'd1, 3'd0, 3'd1};

  initial begin
    rst = 1'b1; req = 8'hFF; mode = 1'b0; out_ready = 1'b1;
    rst5 = 1'b1; req5 = '0; mode5 = 1'b0; ready5 = 1'b0;

    // 1: reset, then fixed priority with all requests
    tick();
    chk8("t1_reset", 1'b0, 3'd0, 8'h00, 3'd0);
    rst = 1'b0;
    tick();
    chk8("t1_g0", 1'b1, 3'd0, 8'h01, 3'd0);
    tick();
    chk8("t1_g1", 1'b1, 3'd0, 8'h01, 3'd0);
    req = 8'h94;
    tick();
    chk8("t1_fixed94", 1'b1, 3'd2, 8'h04, 3'd0);

    // 2: round-robin over bits 2,4,7
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b1; req = 8'h94; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk8($sformatf("t2_rr%0d", i), 1'b1, rr_code[i], rr_oh[i], rr_ptr[i]);
    end

    // 4: stalled grant is frozen against req changes
    rst = 1'b1; tick(); rst = 1'b0;
    mode = 1'b0; req = 8'h08; out_ready = 1'b0;
    tick();
    chk8("t4_cap", 1'b1, 3'd3, 8'h08, 3'd0);
    req = 8'h01;
    tick();
    chk8("t4_hold1", 1'b1, 3'd3, 8'h08, 3'd0);
    req = 8'h00;
    tick();
    chk8("t4_hold2", 1'b1, 3'd3, 8'h08, 3'd0);
    tick();
    chk8("t4_hold3", 1'b1, 3'd3, 8'h08, 3'd0);
    out_ready = 1'b1;
    tick();
    chk8("t4_empty", 1'b0, 3'd0, 8'h00, 3'd0);

    // 5: idle with no requests after reset
    rst = 1'b1; tick(); rst = 1'b0;
    req = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk8($sformatf("t5_idle%0d", i), 1'b0, 3'd0, 8'h00, 3'd0);
    end

    // 6: reset during a stalled round-robin grant with ptr=6
    mode = 1'b1; out_ready = 1'b0; req = 8'h20;
    tick();
    chk8("t6_cap5", 1'b1, 3'd5, 8'h20, 3'd0);
    out_ready = 1'b1; req = 8'h40;
    tick();
    chk8("t6_cap6", 1'b1, 3'd6, 8'h40, 3'd6);
    out_ready = 1'b0;
    tick();
    chk8("t6_stall", 1'b1, 3'd6, 8'h40, 3'd6);
    rst = 1'b1;
    tick();
    chk8("t6_reset", 1'b0, 3'd0, 8'h00, 3'd0);
    rst = 1'b0; req = 8'h41;
    tick();
    chk8("t6_after", 1'b1, 3'd0, 8'h01, 3'd0);

    // 3: N=5 round-robin wraps at index 4
    mode5 = 1'b1; req5 = 5'b10001; ready5 = 1'b1;
    tick();
    chk("t3_reset.valid", 32'(valid5), 32'd0);
    chk("t3_reset.ptr",   32'(ptr5),   32'd0);
    rst5 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t3_g%0d.valid", i),  32'(valid5),  32'd1);
      chk($sformatf("t3_g%0d.code", i),   32'(code5),   32'(w5_code[i]));
      chk($sformatf("t3_g%0d.onehot", i), 32'(onehot5), 32'(w5_oh[i]));
      chk($sformatf("t3_g%0d.ptr", i),    32'(ptr5),    32'(w5_ptr[i]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
